// File: rtl/vic_addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// vic_addr_gen_pkg
// Shared definitions for the VIC-II address generator:
//   - vic_cycle_t     : bus-cycle classification codes (VIC_*)
//   - IDLE_ADDR       : address driven when the VIC has nothing to fetch
//   - ECM_MASK        : extended-colour-mode mask applied to g-accesses
//   - REFRESH_PREFIX  : upper address bits of a DRAM refresh cycle
// -----------------------------------------------------------------------------
package vic_addr_gen_pkg;

    typedef enum logic [3:0] {
        VIC_LP   = 4'd0,   // sprite pointer fetch (low phase)
        VIC_LPI2 = 4'd1,   // idle in sprite pointer slot
        VIC_LS2  = 4'd2,   // sprite data fetch, byte 2
        VIC_LR   = 4'd3,   // DRAM refresh
        VIC_LG   = 4'd4,   // graphics fetch
        VIC_HS1  = 4'd5,   // sprite data fetch, byte 1
        VIC_HPI1 = 4'd6,   // idle high phase, sprite slot
        VIC_HPI3 = 4'd7,   // idle high phase, sprite slot
        VIC_HS3  = 4'd8,   // sprite data fetch, byte 3
        VIC_HRC  = 4'd9,   // character pointer fetch after refresh
        VIC_HGC  = 4'd10,  // character pointer fetch after graphics
        VIC_HGI  = 4'd11,  // high phase after graphics, no c-access
        VIC_HI   = 4'd12,  // high phase idle
        VIC_LI   = 4'd13,  // low phase idle
        VIC_HRX  = 4'd14   // high phase after refresh, no c-access
    } vic_cycle_t;

    localparam logic [13:0] IDLE_ADDR      = 14'h3fff;
    localparam logic [13:0] ECM_MASK       = 14'h39ff;
    localparam logic [5:0]  REFRESH_PREFIX = 6'h3f;

endpackage

// File: rtl/vic_addr_gen_video_counters.sv
// -----------------------------------------------------------------------------
// vic_video_counters
// Video matrix counter VC, its line base VCBASE, row counter RC and the
// display/idle state. Updates only on low-phase strobes.
// Ports:
//   clk_dot4x, rst     : clock, synchronous active-high reset
//   strobe_lo          : address-setup strobe during phi = 0
//   is_lg              : current cycle is a g-access
//   cycle_num          : raster cycle number, 0-based
//   frame_start        : raster line 0
//   badline            : bad-line condition
//   vc, rc, idle       : current counter values / idle state
// -----------------------------------------------------------------------------
module vic_video_counters
    import vic_addr_gen_pkg::*;
#(
    parameter logic [6:0] VC_LOAD_CYCLE   = 7'd13,
    parameter logic [6:0] RC_UPDATE_CYCLE = 7'd57
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic       strobe_lo,
    input  logic       is_lg,
    input  logic [6:0] cycle_num,
    input  logic       frame_start,
    input  logic       badline,
    output logic [9:0] vc,
    output logic [2:0] rc,
    output logic       idle
);

    logic [9:0] vc_q, vc_d;
    logic [9:0] vcbase_q, vcbase_d;
    logic [2:0] rc_q, rc_d;
    logic       idle_q, idle_d;

    // The update steps are ordered: later steps see the results of earlier
    // ones within the same strobe, so they are chained through the _d values.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves it
        // unassigned and no latch is inferred.
        vc_d     = vc_q;
        vcbase_d = vcbase_q;
        rc_d     = rc_q;
        idle_d   = idle_q;

        if (strobe_lo) begin
            if (frame_start) begin
                vcbase_d = 10'd0;
            end
            // The address of this g-access already used the old VC.
            if (is_lg && !idle_q) begin
                vc_d = vc_q + 10'd1;
            end
            if (cycle_num == VC_LOAD_CYCLE) begin
                vc_d = vcbase_d;
                if (badline) begin
                    rc_d = 3'd0;
                end
            end
            // A bad line always forces display state, and beats idle entry below.
            if (badline) begin
                idle_d = 1'b0;
            end
            if (cycle_num == RC_UPDATE_CYCLE) begin
                if (rc_d == 3'd7) begin
                    vcbase_d = vc_d;
                    if (!badline) begin
                        idle_d = 1'b1;
                    end
                end
                if (!idle_d) begin
                    rc_d = rc_d + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_dot4x) begin
        // NOTE: sequential state uses non-blocking assignments only; the
        // blocking chain above lives purely in combinational logic.
        if (rst) begin
            vc_q     <= 10'd0;
            vcbase_q <= 10'd0;
            rc_q     <= 3'd0;
            idle_q   <= 1'b1;
        end else begin
            vc_q     <= vc_d;
            vcbase_q <= vcbase_d;
            rc_q     <= rc_d;
            idle_q   <= idle_d;
        end
    end

    assign vc   = vc_q;
    assign rc   = rc_q;
    assign idle = idle_q;

endmodule

// File: rtl/vic_addr_gen.sv
// -----------------------------------------------------------------------------
// vic_addr_gen
// Drives the VIC-II 14-bit address for c/g/p/s/refresh accesses. Holds the
// refresh counter and the registered address mux; video counters live in
// vic_video_counters.
// Ports:
//   clk_dot4x, rst        : clock, synchronous active-high reset
//   phi                   : phi2 phase (0 low, 1 high)
//   phi_phase_start_das   : address-setup strobe, one clock per phase
//   cycle_num, cycle_type : raster cycle number and classification
//   frame_start, badline  : raster line 0 / bad-line condition
//   vm, cb, bmm, ecm      : $D018 bases and mode bits
//   char_next             : current character code, [7:0] used
//   sprite_cnt            : sprite index for p/s accesses
//   sprite_ptr_o          : 8 x 8-bit sprite pointers, sprite 0 in MSBs
//   sprite_mc             : 8 x 6-bit sprite MC counters, sprite 0 in MSBs
//   ado                   : registered address (1 clock after strobe)
//   idle, vc_o, rc_o      : display state and counter visibility
// -----------------------------------------------------------------------------
module vic_addr_gen
    import vic_addr_gen_pkg::*;
#(
    parameter logic [6:0] VC_LOAD_CYCLE   = 7'd13,
    parameter logic [6:0] RC_UPDATE_CYCLE = 7'd57
) (
    input  logic        clk_dot4x,
    input  logic        rst,
    input  logic        phi,
    input  logic        phi_phase_start_das,
    input  logic [6:0]  cycle_num,
    input  logic [3:0]  cycle_type,
    input  logic        frame_start,
    input  logic        badline,
    input  logic [3:0]  vm,
    input  logic [2:0]  cb,
    input  logic        bmm,
    input  logic        ecm,
    input  logic [11:0] char_next,
    input  logic [2:0]  sprite_cnt,
    input  logic [63:0] sprite_ptr_o,
    input  logic [47:0] sprite_mc,
    output logic [13:0] ado,
    output logic        idle,
    output logic [9:0]  vc_o,
    output logic [2:0]  rc_o
);

    vic_cycle_t  ctype;
    logic        strobe_lo;
    logic [9:0]  vc;
    logic [2:0]  rc;
    logic [7:0]  refc_q, refc_d;
    logic [13:0] ado_q, ado_d;
    logic [13:0] g_addr;
    logic [7:0]  spr_ptr [8];
    logic [5:0]  spr_mc  [8];
    logic        char_hi_unused;

    assign ctype          = vic_cycle_t'(cycle_type);
    assign strobe_lo      = phi_phase_start_das & ~phi;
    assign char_hi_unused = ^char_next[11:8];

    vic_video_counters #(
        .VC_LOAD_CYCLE   (VC_LOAD_CYCLE),
        .RC_UPDATE_CYCLE (RC_UPDATE_CYCLE)
    ) u_counters (
        .clk_dot4x   (clk_dot4x),
        .rst         (rst),
        .strobe_lo   (strobe_lo),
        .is_lg       (ctype == VIC_LG),
        .cycle_num   (cycle_num),
        .frame_start (frame_start),
        .badline     (badline),
        .vc          (vc),
        .rc          (rc),
        .idle        (idle)
    );

    // Sprite 0 occupies the most significant slice of each flattened bus.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            spr_ptr[i] = sprite_ptr_o[(7 - i) * 8 +: 8];
            spr_mc[i]  = sprite_mc[(7 - i) * 6 +: 6];
        end
    end

    // Frame start reloads REFC and wins over a same-strobe decrement.
    always_comb begin
        refc_d = refc_q;
        if (strobe_lo) begin
            if (frame_start) begin
                refc_d = 8'hff;
            end else if (ctype == VIC_LR) begin
                refc_d = refc_q - 8'd1;
            end
        end
    end

    // ECM masking applies in both display and idle state.
    always_comb begin
        if (idle) begin
            g_addr = IDLE_ADDR;
        end else if (bmm) begin
            g_addr = {cb[2], vc, rc};
        end else begin
            g_addr = {cb, char_next[7:0], rc};
        end
        if (ecm) begin
            g_addr = g_addr & ECM_MASK;
        end
    end

    always_comb begin
        ado_d = ado_q;
        if (phi_phase_start_das) begin
            case (ctype)
                VIC_HRC, VIC_HGC:          ado_d = {vm, vc};
                VIC_LG:                    ado_d = g_addr;
                VIC_LP:                    ado_d = {vm, 7'h7f, sprite_cnt};
                VIC_LS2, VIC_HS1, VIC_HS3: ado_d = {spr_ptr[sprite_cnt], spr_mc[sprite_cnt]};
                VIC_LR:                    ado_d = {REFRESH_PREFIX, refc_q};
                default:                   ado_d = IDLE_ADDR;
            endcase
        end
    end

    always_ff @(posedge clk_dot4x) begin
        // NOTE: reset is synchronous and checked first, so it overrides any
        // strobe in the same clock.
        if (rst) begin
            refc_q <= 8'hff;
            ado_q  <= IDLE_ADDR;
        end else begin
            refc_q <= refc_d;
            ado_q  <= ado_d;
        end
    end

    assign ado  = ado_q;
    assign vc_o = vc;
    assign rc_o = rc;

endmodule

// File: tb/tb_vic_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_vic_addr_gen
// Directed stimulus for vic_addr_gen with an arithmetic reference model and
// a per-cycle compare process, plus literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_vic_addr_gen;
    import vic_addr_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        phi;
    logic        das;
    logic [6:0]  cycle_num;
    logic [3:0]  cycle_type;
    logic        frame_start;
    logic        badline;
    logic [3:0]  vm;
    logic [2:0]  cb;
    logic        bmm;
    logic        ecm;
    logic [11:0] char_next;
    logic [2:0]  sprite_cnt;
    logic [63:0] sprite_ptr_o;
    logic [47:0] sprite_mc;
    logic [13:0] ado;
    logic        idle;
    logic [9:0]  vc_o;
    logic [2:0]  rc_o;

    vic_addr_gen dut (
        .clk_dot4x           (clk),
        .rst                 (rst),
        .phi                 (phi),
        .phi_phase_start_das (das),
        .cycle_num           (cycle_num),
        .cycle_type          (cycle_type),
        .frame_start         (frame_start),
        .badline             (badline),
        .vm                  (vm),
        .cb                  (cb),
        .bmm                 (bmm),
        .ecm                 (ecm),
        .char_next           (char_next),
        .sprite_cnt          (sprite_cnt),
        .sprite_ptr_o        (sprite_ptr_o),
        .sprite_mc           (sprite_mc),
        .ado                 (ado),
        .idle                (idle),
        .vc_o                (vc_o),
        .rc_o                (rc_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    int m_vc, m_vcbase, m_rc, m_idle, m_refc, m_ado;
    int sp_ptr [8];
    int sp_mc  [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vc = 0; m_vcbase = 0; m_rc = 0; m_idle = 1; m_refc = 255; m_ado = 'h3fff;
    endtask

    task automatic pack_sprites();
        for (int i = 0; i < 8; i++) begin
            sprite_ptr_o[(7 - i) * 8 +: 8] = 8'(sp_ptr[i]);
            sprite_mc[(7 - i) * 6 +: 6]    = 6'(sp_mc[i]);
        end
    endtask

    // Apply one strobe's worth of rules to the model using plain arithmetic.
    task automatic model_step(input bit ph, input logic [3:0] ct, input int cyc);
        int addr;
        int was_idle;
        was_idle = m_idle;
        if (ct == VIC_HRC || ct == VIC_HGC)
            addr = int'(vm) * 1024 + m_vc;
        else if (ct == VIC_LG) begin
            if (m_idle != 0)  addr = 'h3fff;
            else if (bmm)     addr = (int'(cb) / 4) * 8192 + m_vc * 8 + m_rc;
            else              addr = int'(cb) * 2048 + (int'(char_next) % 256) * 8 + m_rc;
            if (ecm) addr = addr & 'h39ff;
        end
        else if (ct == VIC_LP)
            addr = int'(vm) * 1024 + 127 * 8 + int'(sprite_cnt);
        else if (ct == VIC_LS2 || ct == VIC_HS1 || ct == VIC_HS3)
            addr = sp_ptr[sprite_cnt] * 64 + sp_mc[sprite_cnt];
        else if (ct == VIC_LR)
            addr = 'h3f00 + m_refc;
        else
            addr = 'h3fff;
        m_ado = addr;

        if (!ph) begin
            if (frame_start) begin
                m_vcbase = 0;
                m_refc = 255;
            end else if (ct == VIC_LR)
                m_refc = (m_refc + 255) % 256;
            if (ct == VIC_LG && was_idle == 0)
                m_vc = (m_vc + 1) % 1024;
            if (cyc == 13) begin
                m_vc = m_vcbase;
                if (badline) m_rc = 0;
            end
            if (badline) m_idle = 0;
            if (cyc == 57) begin
                if (m_rc == 7) begin
                    m_vcbase = m_vc;
                    if (!badline) m_idle = 1;
                end
                if (m_idle == 0) m_rc = (m_rc + 1) % 8;
            end
        end
    endtask

    // One strobe clock followed by one quiet clock; returns at posedge+1.
    task automatic strobe(input bit ph, input logic [3:0] ct, input int cyc);
        phi = ph; cycle_type = ct; cycle_num = 7'(cyc); das = 1'b1;
        @(posedge clk); #1;
        if (rst) model_reset();
        else     model_step(ph, ct, cyc);
        das = 1'b0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ado",  32'(ado),  32'(m_ado));
            check("idle", 32'(idle), 32'(m_idle));
            check("vc",   32'(vc_o), 32'(m_vc));
            check("rc",   32'(rc_o), 32'(m_rc));
        end
    end

    initial begin
        rst = 1'b1; phi = 1'b0; das = 1'b0; cycle_num = '0; cycle_type = VIC_LI;
        frame_start = 1'b0; badline = 1'b0; vm = 4'd0; cb = 3'd0; bmm = 1'b0;
        ecm = 1'b0; char_next = 12'h000; sprite_cnt = 3'd0;
        for (int i = 0; i < 8; i++) begin
            sp_ptr[i] = 'h10 + i;
            sp_mc[i]  = i * 5;
        end
        pack_sprites();

        // Reset with strobes running
        strobe(1'b0, VIC_LR, 0);
        cmp_en = 1'b1;
        strobe(1'b1, VIC_HRC, 1);
        check("rst_ado",  32'(ado),  32'h3fff);
        check("rst_idle", 32'(idle), 32'd1);
        rst = 1'b0;

        // Refresh countdown from REFC = ff
        for (int k = 0; k < 5; k++) begin
            strobe(1'b0, VIC_LR, 2 + k);
            check("refresh_addr", 32'(ado), 32'h3fff - k);
        end

        // Text mode line
        vm = 4'd1; cb = 3'd2; char_next = 12'hf41; badline = 1'b1;
        strobe(1'b0, VIC_LI, 13);
        for (int i = 0; i < 40; i++) begin
            strobe(1'b1, VIC_HRC, 14 + i);
            if (i == 0)  check("c_addr_first", 32'(ado), 32'h0400);
            if (i == 39) check("c_addr_last",  32'(ado), 32'h0427);
            strobe(1'b0, VIC_LG, 15 + i);
            if (i == 0)  check("g_addr_text", 32'(ado), 32'h1208);
        end
        strobe(1'b0, VIC_LI, 57);
        check("text_vc_end", 32'(vc_o), 32'd40);
        check("text_rc_end", 32'(rc_o), 32'd1);
        badline = 1'b0;

        // Bitmap + ECM, idle first
        rst = 1'b1; strobe(1'b0, VIC_LI, 0); rst = 1'b0;
        bmm = 1'b1; ecm = 1'b1; cb = 3'd4;
        strobe(1'b0, VIC_LG, 15);
        check("g_idle_ecm", 32'(ado), 32'h39ff);
        badline = 1'b1; strobe(1'b0, VIC_LI, 13); badline = 1'b0;
        for (int i = 0; i < 5; i++) strobe(1'b0, VIC_LG, 15 + i);
        for (int i = 0; i < 3; i++) strobe(1'b0, VIC_LI, 57);
        strobe(1'b0, VIC_LG, 20);
        check("g_bmm_ecm", 32'(ado), 32'h202b);
        bmm = 1'b0; ecm = 1'b0;

        // Idle entry at RC = 7, VC = 6
        for (int i = 0; i < 4; i++) strobe(1'b0, VIC_LI, 57);
        check("rc_before_entry", 32'(rc_o), 32'd7);
        strobe(1'b0, VIC_LI, 57);
        check("idle_entry_idle", 32'(idle), 32'd1);
        check("idle_entry_rc",   32'(rc_o), 32'd7);
        strobe(1'b0, VIC_LI, 13);
        check("vcbase_latched", 32'(vc_o), 32'd6);
        badline = 1'b1;
        strobe(1'b0, VIC_LI, 57);
        check("badline_idle", 32'(idle), 32'd0);
        check("badline_rc",   32'(rc_o), 32'd0);
        badline = 1'b0;

        // Sprites
        vm = 4'd1; sprite_cnt = 3'd3; sp_ptr[3] = 'h80; sp_mc[3] = 'h15; pack_sprites();
        strobe(1'b0, VIC_LP, 58);
        check("p_access", 32'(ado), 32'h07fb);
        strobe(1'b1, VIC_HS1, 59);
        check("s_access", 32'(ado), 32'h2015);

        // Frame start overrides refresh decrement
        strobe(1'b0, VIC_LR, 60);
        frame_start = 1'b1; strobe(1'b0, VIC_LR, 61); frame_start = 1'b0;
        strobe(1'b0, VIC_LR, 62);
        check("frame_refc", 32'(ado), 32'h3fff);

        // VC wrap
        badline = 1'b1; strobe(1'b0, VIC_LI, 13); badline = 1'b0;
        for (int i = 0; i < 1023; i++) strobe(1'b0, VIC_LG, 15);
        check("vc_max", 32'(vc_o), 32'h3ff);
        strobe(1'b0, VIC_LG, 15);
        check("vc_wrap", 32'(vc_o), 32'h000);

        // Reset mid-line
        for (int i = 0; i < 3; i++) strobe(1'b0, VIC_LG, 16);
        strobe(1'b0, VIC_LI, 57);
        strobe(1'b0, VIC_LR, 58);
        rst = 1'b1;
        strobe(1'b0, VIC_LG, 20);
        check("mid_rst_ado",  32'(ado),  32'h3fff);
        check("mid_rst_idle", 32'(idle), 32'd1);
        check("mid_rst_vc",   32'(vc_o), 32'd0);
        check("mid_rst_rc",   32'(rc_o), 32'd0);
        rst = 1'b0;
        strobe(1'b0, VIC_LR, 21);
        check("mid_rst_refc", 32'(ado), 32'h3fff);

        cmp_en = 1'b0;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vic_addr_gen.md
Name: vic_addr_gen

Overview:
- Drives the VIC-II 14-bit address bus for every VIC-owned bus cycle.
  - c-access: character pointer fetch.
  - g-access: graphics fetch.
  - p-access: sprite pointer fetch.
  - s-access: sprite data fetch.
  - r-access: DRAM refresh.
- It is the address side of the same bus whose returned data is latched by the data-read path.
- Owns the video counters VC, VCBASE and RC, the refresh counter REFC, and the display/idle state. Exports `idle` to the data-read path.

Parameters:
- VC_LOAD_CYCLE, 7'd13: cycle_num at which VC is reloaded from VCBASE (cycle 14, 1-based).
- RC_UPDATE_CYCLE, 7'd57: cycle_num at which RC and VCBASE are updated (cycle 58, 1-based).

Ports:
- clk_dot4x  in  1  system clock. All logic is synchronous to this clock.
- rst  in  1  synchronous, active-high reset.
- phi  in  1  current phi2 phase (0 = low phase, 1 = high phase).
- phi_phase_start_das  in  1  one-clock strobe marking the address-setup point of each phase.
- cycle_num  in  7  current raster cycle number, 0-based.
- cycle_type  in  4  cycle classification, using the shared `VIC_*` codes.
- frame_start  in  1  high during raster line 0. Sampled on low-phase strobes only.
- badline  in  1  bad-line condition for the current cycle.
- vm  in  4  video matrix base ($D018[7:4]).
- cb  in  3  character/bitmap base ($D018[3:1]).
- bmm  in  1  bitmap mode.
- ecm  in  1  extended colour mode.
- char_next  in  12  current character from the data-read path. Bits [7:0] are used.
- sprite_cnt  in  3  sprite index for p/s cycles.
- sprite_ptr_o  in  64  flattened sprite pointers, sprite 0 in bits [63:56].
- sprite_mc  in  48  flattened sprite MC counters, 6 bits each, sprite 0 in bits [47:42].
- ado  out  14  registered VIC address.
- idle  out  1  1 = idle state, 0 = display state.
- vc_o  out  10  current VC value, for debug/verification.
- rc_o  out  3  current RC value, for debug/verification.

Behaviour:
- Reset values: ado = 14'h3fff, idle = 1, VC = 0, VCBASE = 0, RC = 0, REFC = 8'hff.
- Reset wins over every other event in the same clock.
- A strobe is `phi_phase_start_das` = 1.
  - Nothing changes between strobes; all registers hold.
- ado is updated on every strobe. The new value is visible the clock after the strobe (1-clock latency).
- ado selection by cycle_type:
  - `VIC_HRC`, `VIC_HGC` (c-access): {vm, VC}.
  - `VIC_LG` (g-access), display state:
    - bmm = 1: {cb[2], VC, RC}.
    - bmm = 0: {cb, char_next[7:0], RC}.
  - `VIC_LG`, idle state: 14'h3fff.
  - `VIC_LG`, ecm = 1 (either state): the chosen address is additionally ANDed with 14'h39ff.
  - `VIC_LP` (p-access): {vm, 7'h7f, sprite_cnt}.
  - Sprite s-access types: {ptr[sprite_cnt], mc[sprite_cnt]}.
  - `VIC_LR` (refresh): {6'h3f, REFC}.
  - Any other type: 14'h3fff.
- Counter updates happen only on strobes with phi = 0. Within one such strobe they apply in this order:
  1. frame_start = 1: VCBASE <= 0, REFC <= 8'hff. This overrides any REFC decrement in the same strobe.
  2. `VIC_LR`: REFC <= REFC - 1, 8-bit wrap (8'h00 -> 8'hff).
  3. `VIC_LG` with idle = 0: VC <= VC + 1, 10-bit wrap (10'h3ff -> 0). The address uses the pre-increment VC.
  4. cycle_num == VC_LOAD_CYCLE: VC <= VCBASE. If badline, RC <= 0.
  5. cycle_num == RC_UPDATE_CYCLE:
     - If RC == 7: VCBASE <= VC, and idle <= 1 unless badline.
     - If display state after that step: RC <= RC + 1, 3-bit wrap.
- badline = 1 on any phi = 0 strobe forces idle <= 0.
  - badline has priority over the RC == 7 idle entry in the same strobe.
- c-access addresses use the current VC; c-access itself does not change VC.
- RC == 7 with badline at RC_UPDATE_CYCLE: RC wraps 7 -> 0 and the block stays in display state.

Decomposition:
- Shared package (common.vh):
  - `VIC_*` cycle-type codes.
  - IDLE_ADDR = 14'h3fff.
  - ECM_MASK = 14'h39ff.
  - REFRESH_PREFIX = 6'h3f.
- Natural sub-module: vic_video_counters, holding VC/VCBASE/RC/idle.
- Refresh counter and address mux stay in the top module.

Test Plan:
- Reset: assert rst with strobes running -> ado = 3fff, idle = 1, REFC = ff. Then 5 `VIC_LR` low strobes -> addresses 3fff, 3ffe, 3ffd, 3ffc, 3ffb.
- Text mode: vm = 1, cb = 2, badline at cycle 13, VCBASE = 0, 40 HRC/LG pairs with char_next = 8'h41.
  - c-addresses 0400..0427.
  - g-addresses 1208 (RC = 0).
  - VC = 40 at line end.
  - RC = 1 after cycle 57.
- Bitmap + ECM: bmm = 1, ecm = 1, cb = 4, VC = 5, RC = 3 -> g address = (2000 | 5<<3 | 3) & 39ff = 202b. With idle = 1 and ecm = 1 -> 39ff.
- Idle entry: RC = 7 at cycle 57, no badline -> VCBASE = VC, idle = 1, RC = 7. Same with badline high -> idle = 0, RC = 0.
- Sprites: sprite_cnt = 3, vm = 1, ptr[3] = 8'h80, mc[3] = 6'h15.
  - p-access -> 07fb.
  - s-access -> 2015.
- Wrap/priority cases:
  - frame_start with `VIC_LR` in the same strobe -> REFC = ff.
  - VC = 3ff with a display g-access -> VC = 000.
  - rst asserted mid-line -> all reset values on the next clock.
